// File: rtl/rx_pkg.sv
// rx_pkg: shared flit-width defines (FLIT_BITS) and receiver FSM types
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 5
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 3
`endif
`ifndef FLIT_BITS
`define FLIT_BITS (`PAYLOAD_SIZE+`ADDR_BITS)
`endif
package rx_pkg;
  localparam int FW = `FLIT_BITS;
  localparam int CNW = $clog2(FW);
  typedef enum logic {IDLE, SHIFT} rx_state_e;
endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: DEPTH-entry flit queue with push/pop, occupancy count and full/empty
module rx_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 8,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  assign count = count_q;
  assign dout = empty ? '0 : mem_q[rd_q];
  assign do_pop = pop && !empty;
  // a full queue still accepts a write when the head leaves on the same edge
  assign do_push = push && (!full || do_pop);
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = do_push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = do_pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk)
    if (reset) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
endmodule

// File: rtl/rx.sv
// rx: serial flit deserialiser feeding rx_fifo; RX_OVERRUN_FLAG_EN adds a sticky overrun output
module rx
  import rx_pkg::*;
#(
  parameter int routerid = -1,
  parameter port = "unknown",
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          serial_in,
  output logic          channel_busy,
  output logic [FW-1:0] parallel_out,
  output logic          out_valid,
  input  logic          out_ack,
  output logic          rx_active
`ifdef RX_OVERRUN_FLAG_EN
  ,
  output logic          overrun
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  rx_state_e state_q, state_d;
  logic [CNW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] shreg_q, shreg_d;
  logic rx_active_q, rx_active_d, done, full, empty;
  logic [CW-1:0] count;
  if (routerid < -1 && port == 0) begin : g_trace
  end
  always_comb begin
    done = state_q == SHIFT && cnt_q == CNW'(FW - 1);
    shreg_d = state_q == SHIFT ? {serial_in, shreg_q[FW-1:1]} : shreg_q;
    cnt_d = state_q == SHIFT && !done ? cnt_q + 1'b1 : '0;
    state_d = done ? IDLE : (state_q == IDLE && serial_in) ? SHIFT : state_q;
    rx_active_d = state_d == SHIFT;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shreg_q <= '0;
      rx_active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shreg_q <= shreg_d;
      rx_active_q <= rx_active_d;
    end
  rx_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clk(clk), .reset(reset), .push(done), .pop(out_ack), .din(shreg_d),
    .dout(parallel_out), .count(count), .full(full), .empty(empty)
  );
  assign rx_active = rx_active_q;
  assign out_valid = !empty;
  // an in-flight frame already owns a slot, so busy rises one flit early
  assign channel_busy = full || (rx_active_q && count == CW'(DEPTH - 1));
`ifdef RX_OVERRUN_FLAG_EN
  logic overrun_q, overrun_d;
  assign overrun_d = overrun_q || (done && full && !out_ack);
  always_ff @(posedge clk) overrun_q <= reset ? 1'b0 : overrun_d;
  assign overrun = overrun_q;
`endif
endmodule

// File: tb/tb_rx.sv
// tb_rx: scoreboard bench for rx, expected flits queued as frames are sent
module tb_rx;
  import rx_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 1'b0, reset = 1'b1, serial_in = 1'b0, out_ack = 1'b0;
  logic channel_busy, out_valid, rx_active;
  logic [FW-1:0] parallel_out;
`ifdef RX_OVERRUN_FLAG_EN
  logic overrun;
`endif
  int tests = 0, fails = 0;
  logic [FW-1:0] sb[$];
  always #5 clk = ~clk;
  rx #(.routerid(0), .port("tb"), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .channel_busy(channel_busy),
    .parallel_out(parallel_out), .out_valid(out_valid), .out_ack(out_ack), .rx_active(rx_active)
`ifdef RX_OVERRUN_FLAG_EN
    , .overrun(overrun)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pop_check(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 1);
    if (sb.size() > 0) begin
      check(tag, 32'(parallel_out), 32'(sb[0]));
      sb.pop_front();
    end
    out_ack = 1'b1;
    tick;
    out_ack = 1'b0;
  endtask
  task automatic send(input logic [FW-1:0] d, input bit ack_last, output int act, output logic busy_s);
    serial_in = 1'b1;
    tick;
    act = int'(rx_active);
    busy_s = channel_busy;
    for (int i = 0; i < FW; i++) begin
      serial_in = d[i];
      if (i == FW - 1 && ack_last && sb.size() > 0) begin
        check("head_at_ack", 32'(parallel_out), 32'(sb[0]));
        sb.pop_front();
        out_ack = 1'b1;
      end
      tick;
      act += int'(rx_active);
    end
    out_ack = 1'b0;
    serial_in = 1'b0;
    if (sb.size() < DEPTH) sb.push_back(d);
  endtask
  initial begin
    int act;
    logic b;
    repeat (2) tick;
    check("rst_active", 32'(rx_active), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_pout", 32'(parallel_out), 0);
    check("rst_busy", 32'(channel_busy), 0);
`ifdef RX_OVERRUN_FLAG_EN
    check("rst_overrun", 32'(overrun), 0);
`endif
    reset = 1'b0;
    tick;
    send(8'hA5, 1'b0, act, b);
    check("a5_active_cycles", 32'(act), FW);
    check("a5_active_low", 32'(rx_active), 0);
    check("a5_busy", 32'(channel_busy), 0);
    pop_check("a5_data");
    check("a5_empty", 32'(out_valid), 0);
    send(8'h01, 1'b0, act, b);
    check("b2b_busy_first", 32'(b), 0);
    send(8'h02, 1'b0, act, b);
    check("b2b_busy_second", 32'(b), 1);
    check("b2b_busy_full", 32'(channel_busy), 1);
    pop_check("b2b_01");
    check("b2b_head", 32'(parallel_out), 32'h02);
    check("b2b_busy_freed", 32'(channel_busy), 0);
    pop_check("b2b_02");
    send(8'h11, 1'b0, act, b);
    send(8'h22, 1'b0, act, b);
    send(8'h33, 1'b0, act, b);
    check("drop_busy", 32'(channel_busy), 1);
`ifdef RX_OVERRUN_FLAG_EN
    check("drop_overrun", 32'(overrun), 1);
`endif
    pop_check("drop_11");
    pop_check("drop_22");
    check("drop_empty", 32'(out_valid), 0);
`ifdef RX_OVERRUN_FLAG_EN
    check("overrun_sticky", 32'(overrun), 1);
`endif
    reset = 1'b1;
    tick;
    reset = 1'b0;
`ifdef RX_OVERRUN_FLAG_EN
    check("overrun_cleared", 32'(overrun), 0);
`endif
    send(8'h66, 1'b0, act, b);
    send(8'h77, 1'b0, act, b);
    send(8'h44, 1'b1, act, b);
    check("same_edge_busy", 32'(channel_busy), 1);
`ifdef RX_OVERRUN_FLAG_EN
    check("same_edge_no_overrun", 32'(overrun), 0);
`endif
    pop_check("same_edge_77");
    pop_check("same_edge_44");
    check("same_edge_empty", 32'(out_valid), 0);
    send(8'h3C, 1'b0, act, b);
    serial_in = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) tick;
    reset = 1'b1;
    tick;
    check("midrst_active", 32'(rx_active), 0);
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_pout", 32'(parallel_out), 0);
    check("midrst_busy", 32'(channel_busy), 0);
    sb.delete();
    reset = 1'b0;
    serial_in = 1'b0;
    tick;
    send(8'h5A, 1'b0, act, b);
    check("5a_active_cycles", 32'(act), FW);
    pop_check("5a_data");
    out_ack = 1'b1;
    repeat (3) tick;
    out_ack = 1'b0;
    check("idle_ack_valid", 32'(out_valid), 0);
    check("idle_ack_active", 32'(rx_active), 0);
    check("idle_ack_busy", 32'(channel_busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
